// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the 5-stage MIPS pipeline registers.
//   ctrl_t      : decoded control bundle carried from ID into EX
//   OP_*        : opcode constants used by hazard detection
//   BUBBLE_CTRL : all-zero control word injected for a pipeline bubble
//   uses_rt()   : true for opcodes that read rt as a source operand
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam ctrl_t BUBBLE_CTRL = '0;

    // Loads and immediate ops write rt, so only these read it as a source.
    function automatic logic uses_rt(input logic [5:0] opc);
        return (opc == OP_RTYPE) || (opc == OP_SW) || (opc == OP_BEQ);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator. Raises hazard when the EX slot
// holds a valid load whose non-zero destination rt is read by the valid
// instruction currently in decode.
// Ports:
//   ex_valid, ex_mem_read, ex_rt : load candidate currently in EX
//   id_valid, id_rs, id_rt, id_opc : consumer candidate currently in ID
//   hazard                       : raw load-use hazard (before flush masking)
// -----------------------------------------------------------------------------
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic          ex_valid,
    input  logic          ex_mem_read,
    input  logic [RW-1:0] ex_rt,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [5:0]    id_opc,
    output logic          hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    assign rt_match = uses_rt(id_opc) && (ex_rt == id_rt);

    // A load into $0 produces nothing to wait for.
    assign hazard = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid
                    && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
// ID/EX pipeline register with load-use stall and branch-flush bubbling.
// Parameters: DW (datapath width), RW (register specifier width).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_valid, id_rs/rt/rd,
//   id_opc, id_rd1/rd2/imm,
//   id_ctrl                  : decoded instruction from ID
//   flush                    : taken branch/jump, discard decode slot
//   ex_*                     : registered copy for EX / forwarding unit
//   stall                    : combinational hold request for PC and IF/ID
//   stall_cnt, flush_cnt     : saturating event counters, present only when
//                              IDEX_STALL_CNT_EN is defined
// Optional feature macro: IDEX_STALL_CNT_EN
// -----------------------------------------------------------------------------
module id_ex_pipe
    import pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [5:0]    id_opc,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  ctrl_t         id_ctrl,
    input  logic          flush,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_rd,
    output logic [5:0]    ex_opc,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output ctrl_t         ex_ctrl,
    output logic          stall
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    logic          ex_valid_reg;
    logic [RW-1:0] ex_rs_reg;
    logic [RW-1:0] ex_rt_reg;
    logic [RW-1:0] ex_rd_reg;
    logic [5:0]    ex_opc_reg;
    logic [DW-1:0] ex_rd1_reg;
    logic [DW-1:0] ex_rd2_reg;
    logic [DW-1:0] ex_imm_reg;
    ctrl_t         ex_ctrl_reg;
    logic          hazard;
    logic          bubble;

    hazard_detect #(.RW(RW)) u_hazard (
        .ex_valid    (ex_valid_reg),
        .ex_mem_read (ex_ctrl_reg.mem_read),
        .ex_rt       (ex_rt_reg),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_opc      (id_opc),
        .hazard      (hazard)
    );

    // A flushed decode slot is discarded anyway, so holding it would only
    // delay the fetch redirect.
    assign stall  = hazard && !flush;
    assign bubble = flush || stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg <= 1'b0;
            ex_rs_reg    <= '0;
            ex_rt_reg    <= '0;
            ex_rd_reg    <= '0;
            ex_opc_reg   <= '0;
            ex_rd1_reg   <= '0;
            ex_rd2_reg   <= '0;
            ex_imm_reg   <= '0;
            ex_ctrl_reg  <= BUBBLE_CTRL;
        end else begin
            // Data fields load even for a bubble so the forwarding unit sees
            // stable specifiers; only valid and control are squashed.
            ex_rs_reg  <= id_rs;
            ex_rt_reg  <= id_rt;
            ex_rd_reg  <= id_rd;
            ex_opc_reg <= id_opc;
            ex_rd1_reg <= id_rd1;
            ex_rd2_reg <= id_rd2;
            ex_imm_reg <= id_imm;
            if (bubble) begin
                ex_valid_reg <= 1'b0;
                ex_ctrl_reg  <= BUBBLE_CTRL;
            end else begin
                ex_valid_reg <= id_valid;
                ex_ctrl_reg  <= id_ctrl;
            end
        end
    end

    assign ex_valid = ex_valid_reg;
    assign ex_rs    = ex_rs_reg;
    assign ex_rt    = ex_rt_reg;
    assign ex_rd    = ex_rd_reg;
    assign ex_opc   = ex_opc_reg;
    assign ex_rd1   = ex_rd1_reg;
    assign ex_rd2   = ex_rd2_reg;
    assign ex_imm   = ex_imm_reg;
    assign ex_ctrl  = ex_ctrl_reg;

`ifdef IDEX_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (flush && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule
